keypad_entry_scanner: RTL and testbench

KEYPAD_ENTRY_SCANNER -- requirements
Module: keypad_entry_scanner

---
 rtl/keypad_entry_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_entry_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_scanner.sv
// rtl/keypad_entry_scanner.sv - 4x4 matrix keypad scanner with debounce and 4-digit BCD entry buffer
module keypad_entry_scanner #(
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_tick,
    input  logic [3:0]  keypad_col,
    output logic [3:0]  keypad_row,
    input  logic        entry_en,
    input  logic        clear_req,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] input_data,
    output logic [2:0]  digit_count,
    output logic        enter_pulse,
    output logic [15:0] code_out,
    output logic        func_pulse
);

    localparam int CW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_row_idx, w_row_idx_nxt;
    logic [1:0]    r_key_col, w_key_col_nxt;
    logic [CW-1:0] r_count, w_count_nxt, w_count_inc;
    logic [3:0]    r_col_meta, r_col_sync;
    logic [3:0]    w_col_low;
    logic          w_one_low;
    logic [1:0]    w_col_idx;
    logic          w_accept;
    logic [3:0]    w_code;
    logic          w_is_digit, w_is_func, w_is_star, w_is_hash;

    // Two-flop synchronizer for the asynchronous, pulled-up column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= keypad_col;
            r_col_sync <= r_col_meta;
        end
    end

    // Active-low one-hot row drive derived from the row index
    always_comb begin
        keypad_row = ~(4'b0001 << r_row_idx);
    end

    // Column decode: a press is only a single low column; two or more low is ignored
    always_comb begin
        w_col_low   = ~r_col_sync;
        w_count_inc = r_count + 1'b1;
        w_one_low   = 1'b0;
        w_col_idx   = 2'd0;
        case (w_col_low)
            4'b0001: begin w_one_low = 1'b1; w_col_idx = 2'd0; end
            4'b0010: begin w_one_low = 1'b1; w_col_idx = 2'd1; end
            4'b0100: begin w_one_low = 1'b1; w_col_idx = 2'd2; end
            4'b1000: begin w_one_low = 1'b1; w_col_idx = 2'd3; end
            default: begin w_one_low = 1'b0; w_col_idx = 2'd0; end
        endcase
    end

    // Scanner state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_SCAN;
            r_row_idx <= 2'd0;
            r_key_col <= 2'd0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_key_col <= w_key_col_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Scanner next-state: scan rows, debounce a single press, wait for a debounced release
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_key_col_nxt = r_key_col;
        w_count_nxt   = r_count;
        w_accept      = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (scan_tick) begin
                    if (w_one_low) begin
                        w_key_col_nxt  = w_col_idx;
                        w_count_nxt    = '0;
                        w_count_nxt[0] = 1'b1;
                        if (DEBOUNCE_CNT <= 1) begin
                            w_accept    = 1'b1;
                            w_count_nxt = '0;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end else begin
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (scan_tick) begin
                    if (w_one_low && (w_col_idx == r_key_col)) begin
                        if (w_count_inc >= CNT_MAX) begin
                            w_accept    = 1'b1;
                            w_count_nxt = '0;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_count_nxt = w_count_inc;
                        end
                    end else begin
                        // Bounce: abandon the press and resume scanning at the next row
                        w_count_nxt   = '0;
                        w_row_idx_nxt = r_row_idx + 2'd1;
                        w_state_nxt   = S_SCAN;
                    end
                end
            end
            S_HOLD: begin
                if (scan_tick) begin
                    if (w_col_low == 4'b0000) begin
                        if (w_count_inc >= CNT_MAX) begin
                            w_count_nxt   = '0;
                            w_row_idx_nxt = 2'd0;
                            w_state_nxt   = S_SCAN;
                        end else begin
                            w_count_nxt = w_count_inc;
                        end
                    end else begin
                        w_count_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_SCAN;
                w_row_idx_nxt = 2'd0;
                w_count_nxt   = '0;
            end
        endcase
    end

    // Key map lookup from the fixed row and the captured column
    always_comb begin
        w_code = 4'h0;
        case ({r_row_idx, w_key_col_nxt})
            4'b00_00: w_code = 4'h1;
            4'b00_01: w_code = 4'h2;
            4'b00_10: w_code = 4'h3;
            4'b00_11: w_code = 4'hA;
            4'b01_00: w_code = 4'h4;
            4'b01_01: w_code = 4'h5;
            4'b01_10: w_code = 4'h6;
            4'b01_11: w_code = 4'hB;
            4'b10_00: w_code = 4'h7;
            4'b10_01: w_code = 4'h8;
            4'b10_10: w_code = 4'h9;
            4'b10_11: w_code = 4'hC;
            4'b11_00: w_code = 4'hE;
            4'b11_01: w_code = 4'h0;
            4'b11_10: w_code = 4'hF;
            default:  w_code = 4'hD;
        endcase
        w_is_digit = (w_code <= 4'h9);
        w_is_func  = (w_code >= 4'hA) && (w_code <= 4'hD);
        w_is_star  = (w_code == 4'hE);
        w_is_hash  = (w_code == 4'hF);
    end

    // Key event outputs and entry buffer; a clear request beats any buffer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            enter_pulse <= 1'b0;
            func_pulse  <= 1'b0;
            code_out    <= 16'h0000;
            input_data  <= 16'h0000;
            digit_count <= 3'd0;
        end else begin
            key_valid   <= w_accept;
            enter_pulse <= w_accept && w_is_hash;
            func_pulse  <= w_accept && w_is_func;
            if (w_accept) begin
                key_code <= w_code;
            end
            if (w_accept && w_is_hash) begin
                code_out <= input_data;
            end
            if (clear_req || (w_accept && (w_is_star || w_is_hash))) begin
                input_data  <= 16'h0000;
                digit_count <= 3'd0;
            end else if (w_accept && w_is_digit && entry_en && (digit_count < 3'd4)) begin
                input_data  <= {input_data[11:0], w_code};
                digit_count <= digit_count + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// tb/tb_keypad_entry_scanner.sv - self-checking bench for keypad_entry_scanner
module tb_keypad_entry_scanner;

    logic        clk;
    logic        rst;
    logic        scan_tick;
    logic [3:0]  keypad_col;
    logic [3:0]  keypad_row;
    logic        entry_en;
    logic        clear_req;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] input_data;
    logic [2:0]  digit_count;
    logic        enter_pulse;
    logic [15:0] code_out;
    logic        func_pulse;

    // Keypad model: pressed columns pull low only while their row is driven
    logic        press;
    logic [1:0]  key_row;
    logic [3:0]  col_mask;

    int checks;
    int failures;
    int kv_total;

    logic [3:0]  s_code;
    logic [15:0] s_data;
    logic [2:0]  s_cnt;
    logic        s_enter;
    logic        s_func;
    logic [15:0] s_code_out;
    logic        s_found;

    typedef struct {
        logic [3:0]  key;
        logic        en;
        logic [15:0] exp_data;
        logic [2:0]  exp_cnt;
        logic        exp_enter;
        logic        exp_func;
        logic [15:0] exp_code_out;
    } vec_t;

    vec_t vecs [18];

    assign keypad_col = (press && (keypad_row[key_row] == 1'b0)) ? ~col_mask : 4'hF;

    keypad_entry_scanner #(.DEBOUNCE_CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_tick   (scan_tick),
        .keypad_col  (keypad_col),
        .keypad_row  (keypad_row),
        .entry_en    (entry_en),
        .clear_req   (clear_req),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .input_data  (input_data),
        .digit_count (digit_count),
        .enter_pulse (enter_pulse),
        .code_out    (code_out),
        .func_pulse  (func_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (key_valid) kv_total <= kv_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic key_pos(input logic [3:0] code, output logic [1:0] r, output logic [1:0] c);
        case (code)
            4'h1: begin r = 2'd0; c = 2'd0; end
            4'h2: begin r = 2'd0; c = 2'd1; end
            4'h3: begin r = 2'd0; c = 2'd2; end
            4'hA: begin r = 2'd0; c = 2'd3; end
            4'h4: begin r = 2'd1; c = 2'd0; end
            4'h5: begin r = 2'd1; c = 2'd1; end
            4'h6: begin r = 2'd1; c = 2'd2; end
            4'hB: begin r = 2'd1; c = 2'd3; end
            4'h7: begin r = 2'd2; c = 2'd0; end
            4'h8: begin r = 2'd2; c = 2'd1; end
            4'h9: begin r = 2'd2; c = 2'd2; end
            4'hC: begin r = 2'd2; c = 2'd3; end
            4'hE: begin r = 2'd3; c = 2'd0; end
            4'h0: begin r = 2'd3; c = 2'd1; end
            4'hF: begin r = 2'd3; c = 2'd2; end
            default: begin r = 2'd3; c = 2'd3; end
        endcase
    endtask

    // One scan_tick with settling time; returns key_valid as seen after the tick edge
    task automatic do_tick(input logic clr, output logic kv);
        repeat (3) @(negedge clk);
        scan_tick = 1'b1;
        clear_req = clr;
        @(negedge clk);
        scan_tick = 1'b0;
        clear_req = 1'b0;
        kv = key_valid;
    endtask

    task automatic set_key(input logic [3:0] code);
        logic [1:0] r, c;
        key_pos(code, r, c);
        key_row  = r;
        col_mask = 4'b0001 << c;
        press    = 1'b1;
    endtask

    task automatic press_wait(input logic [3:0] code);
        logic kv;
        set_key(code);
        s_found = 1'b0;
        for (int i = 0; i < 16 && !s_found; i++) begin
            do_tick(1'b0, kv);
            if (kv) begin
                s_found    = 1'b1;
                s_code     = key_code;
                s_data     = input_data;
                s_cnt      = digit_count;
                s_enter    = enter_pulse;
                s_func     = func_pulse;
                s_code_out = code_out;
            end
        end
        chk("press_accepted", {31'd0, s_found}, 32'd1);
    endtask

    task automatic release_key();
        logic kv;
        press = 1'b0;
        for (int i = 0; i < 4; i++) do_tick(1'b0, kv);
    endtask

    task automatic ticks(input int n);
        logic kv;
        for (int i = 0; i < n; i++) do_tick(1'b0, kv);
    endtask

    task automatic chk_kv_total(input string name, input int exp);
        #1;
        chk(name, kv_total, exp);
    endtask

    initial begin
        logic kv;
        checks    = 0;
        failures  = 0;
        kv_total  = 0;
        rst       = 1'b1;
        scan_tick = 1'b0;
        entry_en  = 1'b1;
        clear_req = 1'b0;
        press     = 1'b0;
        key_row   = 2'd0;
        col_mask  = 4'b0000;

        vecs[0]  = '{4'hE, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{4'h1, 1'b1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{4'h2, 1'b1, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{4'h3, 1'b1, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{4'h4, 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{4'h9, 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{4'hA, 1'b1, 16'h1234, 3'd4, 1'b0, 1'b1, 16'h0000};
        vecs[7]  = '{4'hF, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h1234};
        vecs[8]  = '{4'h7, 1'b1, 16'h0007, 3'd1, 1'b0, 1'b0, 16'h1234};
        vecs[9]  = '{4'h0, 1'b1, 16'h0070, 3'd2, 1'b0, 1'b0, 16'h1234};
        vecs[10] = '{4'hF, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0070};
        vecs[11] = '{4'hF, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0000};
        vecs[12] = '{4'h3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};
        vecs[13] = '{4'h5, 1'b1, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0000};
        vecs[14] = '{4'hD, 1'b0, 16'h0005, 3'd1, 1'b0, 1'b1, 16'h0000};
        vecs[15] = '{4'hE, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{4'hB, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0000};
        vecs[17] = '{4'hC, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_row", keypad_row, 4'b1110);
        chk("rst_kv", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_data", input_data, 0);
        chk("rst_cnt", digit_count, 0);
        chk("rst_enter", enter_pulse, 0);
        chk("rst_func", func_pulse, 0);
        chk("rst_code_out", code_out, 0);
        rst = 1'b0;

        // Scenario 1: hold '5', one pulse only even after 100 more ticks
        press_wait(4'h5);
        chk("s1_code", s_code, 4'h5);
        chk("s1_data", s_data, 16'h0005);
        chk("s1_cnt", s_cnt, 3'd1);
        ticks(100);
        chk_kv_total("s1_no_repeat", 1);
        chk("s1_data_held", input_data, 16'h0005);
        release_key();

        // Table: digit entry, overflow, functions, '*', '#', entry disabled
        for (int i = 0; i < 18; i++) begin
            entry_en = vecs[i].en;
            press_wait(vecs[i].key);
            chk($sformatf("v%0d_code", i), s_code, vecs[i].key);
            chk($sformatf("v%0d_data", i), s_data, vecs[i].exp_data);
            chk($sformatf("v%0d_cnt", i), s_cnt, vecs[i].exp_cnt);
            chk($sformatf("v%0d_enter", i), s_enter, vecs[i].exp_enter);
            chk($sformatf("v%0d_func", i), s_func, vecs[i].exp_func);
            chk($sformatf("v%0d_code_out", i), s_code_out, vecs[i].exp_code_out);
            release_key();
        end
        entry_en = 1'b1;
        chk_kv_total("table_kv_total", 19);

        // Scenario 5: clear_req on the accepting tick of '6' with two digits stored
        press_wait(4'h1);
        release_key();
        press_wait(4'h2);
        chk("s5_pre_data", s_data, 16'h0012);
        chk("s5_pre_cnt", s_cnt, 3'd2);
        release_key();
        set_key(4'h6);
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, kv);
            chk($sformatf("s5_kv_early%0d", i), kv, 0);
        end
        do_tick(1'b1, kv);
        chk("s5_kv", kv, 1);
        chk("s5_code", key_code, 4'h6);
        chk("s5_data", input_data, 16'h0000);
        chk("s5_cnt", digit_count, 3'd0);
        chk("s5_code_out", code_out, 16'h0000);
        release_key();
        chk_kv_total("s5_kv_total", 22);

        // Standalone clear_req leaves code_out alone
        press_wait(4'h4);
        release_key();
        press_wait(4'hF);
        chk("clr_enter_code_out", s_code_out, 16'h0004);
        release_key();
        press_wait(4'h8);
        chk("clr_pre_data", s_data, 16'h0008);
        release_key();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_data", input_data, 16'h0000);
        chk("clr_cnt", digit_count, 3'd0);
        chk("clr_code_out", code_out, 16'h0004);
        chk_kv_total("clr_kv_total", 25);

        // Scenario 4: short bounce on '8', then two columns low together
        set_key(4'h8);
        ticks(4);
        press = 1'b0;
        ticks(8);
        chk_kv_total("s4_bounce", 25);
        key_row  = 2'd2;
        col_mask = 4'b0011;
        press    = 1'b1;
        ticks(12);
        press = 1'b0;
        ticks(8);
        chk_kv_total("s4_two_cols", 25);

        // Scenario 6: reset in the middle of debouncing '1'
        press_wait(4'h2);
        chk("s6_pre_data", s_data, 16'h0002);
        release_key();
        set_key(4'h1);
        ticks(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_row", keypad_row, 4'b1110);
        chk("s6_kv", key_valid, 0);
        chk("s6_code", key_code, 0);
        chk("s6_data", input_data, 0);
        chk("s6_cnt", digit_count, 0);
        chk("s6_code_out", code_out, 0);
        chk("s6_enter", enter_pulse, 0);
        chk("s6_func", func_pulse, 0);
        press = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ticks(12);
        chk_kv_total("s6_no_kv", 26);
        chk("s6_data_after", input_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
